dmem_arbiter: RTL and testbench

- Shares the single byte-addressed, big-endian data memory port between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Round-robin arbitration with a bounded hold, so one owner can stream consecutive accesses without starving the other.
- The memory implements only sb (MEM_FUNCT3=0) and sw (MEM_FUNCT3=2) writes, with combinational word reads. This block splits sh into two sb beats and applies RV32 load extension.
- Sits between the LSU/debug masters and the data memory.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_load_ext.sv | 23 ++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: RV32 funct3 codes, memory-port
// write sizes and the arbiter state encoding.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [1:0] MEM_SB = 2'd0;
   localparam logic [1:0] MEM_SW = 2'd2;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StOwn0  = 3'd1,
      StOwn1  = 3'd2,
      StSh2P0 = 3'd3,
      StSh2P1 = 3'd4
   } state_e;

endpackage

// File: rtl/dmem_load_ext.sv
// RV32 load extension of a big-endian memory word; the addressed byte/half sits in the
// top bits.
module dmem_load_ext
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   always_comb begin
      data = '0;
      case (funct3)
         F3_B:    data = {{24{rdata[31]}}, rdata[31:24]};
         F3_BU:   data = {24'h0, rdata[31:24]};
         F3_H:    data = {{16{rdata[31]}}, rdata[31:16]};
         F3_HU:   data = {16'h0, rdata[31:16]};
         F3_W:    data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with bounded hold, sh split into two sb beats,
// RV32 load extension. Define DMEM_MISALIGN_CHECK_EN for alignment checks and ERR0/ERR1.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              WE0,
   input  logic              WE1,
   input  logic [2:0]        FUNCT3_0,
   input  logic [2:0]        FUNCT3_1,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [31:0]       WDATA0,
   input  logic [31:0]       WDATA1,
   output logic              GNT0,
   output logic              GNT1,
   output logic              RVALID0,
   output logic              RVALID1,
   output logic [31:0]       RDATA0,
   output logic [31:0]       RDATA1,
`ifdef DMEM_MISALIGN_CHECK_EN
   output logic              ERR0,
   output logic              ERR1,
`endif
   output logic              MEM_WE,
   output logic [1:0]        MEM_FUNCT3,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [31:0]       MEM_WDATA,
   input  logic [31:0]       MEM_RDATA
);

   localparam int unsigned       HOLD_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                rvalid0_q, rvalid1_q;
   logic [31:0]         rdata0_q, rdata1_q;
   logic [ADDR_W-1:0]   sh_addr_q;
   logic [7:0]          sh_byte_q;

   logic                in_sh2, owner_valid, owner, sel, active;
   logic                cur_we;
   logic [2:0]          cur_f3;
   logic [ADDR_W-1:0]   cur_addr;
   logic [31:0]         cur_wdata;
   logic                misalign, gnt, load_fire, sh_start;
   logic [31:0]         ext_data, load_data;

   assign in_sh2      = (state_q == StSh2P0) || (state_q == StSh2P1);
   assign owner_valid = (state_q == StOwn0) || (state_q == StOwn1);
   assign owner       = (state_q == StOwn1) || (state_q == StSh2P1);
   assign active      = ~RST & (in_sh2 | REQ0 | REQ1);

   // The running owner keeps the port under contention until it has used its hold budget.
   always_comb begin
      if (in_sh2) begin
         sel = owner;
      end else if (REQ0 && REQ1) begin
         sel = (owner_valid && (hold_cnt_q < HOLD_LIMIT)) ? owner : ~last_grant_q;
      end else begin
         sel = REQ1;
      end
   end

   assign cur_we    = sel ? WE1 : WE0;
   assign cur_f3    = sel ? FUNCT3_1 : FUNCT3_0;
   assign cur_addr  = sel ? ADDR1 : ADDR0;
   assign cur_wdata = sel ? WDATA1 : WDATA0;

`ifdef DMEM_MISALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      case (cur_f3)
         F3_H:    misalign = cur_addr[0];
         F3_HU:   misalign = ~cur_we & cur_addr[0];
         F3_W:    misalign = |cur_addr[1:0];
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      hold_cnt_d   = hold_cnt_q;
      gnt          = 1'b0;
      sh_start     = 1'b0;
      MEM_WE       = 1'b0;
      MEM_FUNCT3   = MEM_SW;
      MEM_ADDR     = '0;
      MEM_WDATA    = '0;
      if (!active) begin
         state_d    = StIdle;
         hold_cnt_d = '0;
      end else if (in_sh2) begin
         // Second beat uses values latched at beat 1, so a dropped REQ still commits.
         MEM_WE     = 1'b1;
         MEM_FUNCT3 = MEM_SB;
         MEM_ADDR   = sh_addr_q;
         MEM_WDATA  = {24'h0, sh_byte_q};
         gnt        = 1'b1;
         state_d    = owner ? StOwn1 : StOwn0;
      end else begin
         MEM_ADDR     = cur_addr;
         last_grant_d = sel;
         state_d      = sel ? StOwn1 : StOwn0;
         gnt          = 1'b1;
         if (owner_valid && (owner == sel)) begin
            hold_cnt_d = (hold_cnt_q < HOLD_LIMIT) ? hold_cnt_q + 1'b1 : hold_cnt_q;
         end else begin
            hold_cnt_d = HOLD_W'(1);
         end
         if (cur_we && !misalign) begin
            case (cur_f3)
               F3_B: begin
                  MEM_WE     = 1'b1;
                  MEM_FUNCT3 = MEM_SB;
                  MEM_WDATA  = {24'h0, cur_wdata[7:0]};
               end
               F3_H: begin
                  MEM_WE     = 1'b1;
                  MEM_FUNCT3 = MEM_SB;
                  MEM_WDATA  = {24'h0, cur_wdata[15:8]};
                  gnt        = 1'b0;
                  sh_start   = 1'b1;
                  state_d    = sel ? StSh2P1 : StSh2P0;
               end
               F3_W: begin
                  MEM_WE     = 1'b1;
                  MEM_FUNCT3 = MEM_SW;
                  MEM_WDATA  = cur_wdata;
               end
               default: ;
            endcase
         end
      end
   end

   dmem_load_ext u_load_ext (
      .funct3 (cur_f3),
      .rdata  (MEM_RDATA),
      .data   (ext_data)
   );

   assign load_fire = gnt & ~in_sh2 & ~cur_we;
   assign load_data = misalign ? 32'h0 : ext_data;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         hold_cnt_q   <= '0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         sh_addr_q    <= '0;
         sh_byte_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         hold_cnt_q   <= hold_cnt_d;
         rvalid0_q    <= load_fire & ~sel;
         rvalid1_q    <= load_fire & sel;
         if (load_fire && !sel) rdata0_q <= load_data;
         if (load_fire && sel)  rdata1_q <= load_data;
         if (sh_start) begin
            sh_addr_q <= cur_addr + ADDR_W'(1);
            sh_byte_q <= cur_wdata[7:0];
         end
      end
   end

   assign GNT0    = gnt & ~sel;
   assign GNT1    = gnt & sel;
   assign RVALID0 = rvalid0_q;
   assign RVALID1 = rvalid1_q;
   assign RDATA0  = rdata0_q;
   assign RDATA1  = rdata1_q;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign ERR0 = gnt & ~in_sh2 & misalign & ~sel;
   assign ERR1 = gnt & ~in_sh2 & misalign & sel;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: big-endian byte memory model, load scoreboard per port,
// directed access sequences.
`timescale 1ns/1ps
module tb_dmem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ0, REQ1, WE0, WE1;
   logic [2:0]  FUNCT3_0, FUNCT3_1;
   logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
   logic        GNT0, GNT1, RVALID0, RVALID1;
   logic [31:0] RDATA0, RDATA1;
   logic        MEM_WE;
   logic [1:0]  MEM_FUNCT3;
   logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
`ifdef DMEM_MISALIGN_CHECK_EN
   logic        ERR0, ERR1;
`endif

   always #5 CLK = ~CLK;

   dmem_arbiter #(.MAX_HOLD(4), .ADDR_W(32)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .REQ0       (REQ0),
      .REQ1       (REQ1),
      .WE0        (WE0),
      .WE1        (WE1),
      .FUNCT3_0   (FUNCT3_0),
      .FUNCT3_1   (FUNCT3_1),
      .ADDR0      (ADDR0),
      .ADDR1      (ADDR1),
      .WDATA0     (WDATA0),
      .WDATA1     (WDATA1),
      .GNT0       (GNT0),
      .GNT1       (GNT1),
      .RVALID0    (RVALID0),
      .RVALID1    (RVALID1),
      .RDATA0     (RDATA0),
      .RDATA1     (RDATA1),
`ifdef DMEM_MISALIGN_CHECK_EN
      .ERR0       (ERR0),
      .ERR1       (ERR1),
`endif
      .MEM_WE     (MEM_WE),
      .MEM_FUNCT3 (MEM_FUNCT3),
      .MEM_ADDR   (MEM_ADDR),
      .MEM_WDATA  (MEM_WDATA),
      .MEM_RDATA  (MEM_RDATA)
   );

   // Memory model: 256 bytes, initialised to i ^ 0x5A.
   logic [7:0] mem [256];
   logic       mem_init = 1'b1;
   logic [7:0] ra;
   assign ra        = MEM_ADDR[7:0];
   assign MEM_RDATA = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};

   always @(posedge CLK) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      end else if (MEM_WE) begin
         if (MEM_FUNCT3 == 2'd0) begin
            mem[ra] <= MEM_WDATA[7:0];
         end else if (MEM_FUNCT3 == 2'd2) begin
            mem[ra]        <= MEM_WDATA[31:24];
            mem[ra + 8'd1] <= MEM_WDATA[23:16];
            mem[ra + 8'd2] <= MEM_WDATA[15:8];
            mem[ra + 8'd3] <= MEM_WDATA[7:0];
         end
      end
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   always @(negedge CLK) begin
      if (RVALID0) begin
         if (q0.size() == 0) check("rv0_extra", {31'h0, RVALID0}, 32'h0);
         else check("rdata0", RDATA0, q0.pop_front());
      end
      if (RVALID1) begin
         if (q1.size() == 0) check("rv1_extra", {31'h0, RVALID1}, 32'h0);
         else check("rdata1", RDATA1, q1.pop_front());
      end
   end

   logic        g_we, g_other, g_err;
   logic [1:0]  g_f3;
   logic [31:0] g_addr, g_wdata;

   task automatic idle_all();
      REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; FUNCT3_0 = 3'd2; FUNCT3_1 = 3'd2;
      ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
   endtask

   task automatic drive(input int port, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         REQ0 = 1; WE0 = we; FUNCT3_0 = f3; ADDR0 = addr; WDATA0 = wdata;
      end else begin
         REQ1 = 1; WE1 = we; FUNCT3_1 = f3; ADDR1 = addr; WDATA1 = wdata;
      end
   endtask

   task automatic release_port(input int port);
      if (port == 0) REQ0 = 0;
      else REQ1 = 0;
   endtask

   // Entered and left at posedge+1; latency counts cycles before the GNT cycle.
   task automatic access(input int port, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input string tag);
      int lat;
      bit got;
      drive(port, we, f3, addr, wdata);
      lat = 0;
      got = 0;
      while (!got && lat < 16) begin
         @(negedge CLK);
         if ((port == 0) ? GNT0 : GNT1) begin
            got     = 1;
            g_we    = MEM_WE;
            g_f3    = MEM_FUNCT3;
            g_addr  = MEM_ADDR;
            g_wdata = MEM_WDATA;
            g_other = (port == 0) ? GNT1 : GNT0;
`ifdef DMEM_MISALIGN_CHECK_EN
            g_err   = (port == 0) ? ERR0 : ERR1;
`else
            g_err   = 1'b0;
`endif
         end else begin
            lat++;
         end
      end
      check({tag, "_lat"}, lat, exp_lat);
      @(posedge CLK);
      #1;
      release_port(port);
   endtask

   task automatic do_load(input int port, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp, input string tag);
      if (port == 0) q0.push_back(exp);
      else q1.push_back(exp);
      access(port, 1'b0, f3, addr, 32'h0, 0, tag);
      check({tag, "_rv"}, {31'h0, (port == 0) ? RVALID0 : RVALID1}, 32'h1);
   endtask

   task automatic do_reset();
      RST = 1;
      idle_all();
      @(posedge CLK);
      #1;
      RST = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1;
      idle_all();
      @(posedge CLK);
      #1;
      mem_init = 0;
      @(posedge CLK);
      @(negedge CLK);
      check("rst_gnt", {30'h0, GNT1, GNT0}, 32'h0);
      check("rst_rv", {30'h0, RVALID1, RVALID0}, 32'h0);
      check("rst_we", {31'h0, MEM_WE}, 32'h0);
      check("rst_f3", {30'h0, MEM_FUNCT3}, 32'h2);
      check("rst_addr", MEM_ADDR, 32'h0);
      check("rst_wdata", MEM_WDATA, 32'h0);
      check("rst_rdata0", RDATA0, 32'h0);
      check("rst_rdata1", RDATA1, 32'h0);
      @(posedge CLK);
      #1;
      RST = 0;

      // sw then loads on port 0
      access(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw0");
      check("sw0_we", {31'h0, g_we}, 32'h1);
      check("sw0_f3", {30'h0, g_f3}, 32'h2);
      check("sw0_addr", g_addr, 32'h10);
      check("sw0_wdata", g_wdata, 32'hDEADBEEF);
      check("sw0_other", {31'h0, g_other}, 32'h0);
      do_load(0, 3'd2, 32'h10, 32'hDEADBEEF, "lw0");
      check("lw0_we", {31'h0, g_we}, 32'h0);
      check("lw0_addr", g_addr, 32'h10);
      do_load(0, 3'd4, 32'h11, 32'h000000AD, "lbu0");

      // sh on port 1: two byte beats, GNT on the second only
      drive(1, 1'b1, 3'd1, 32'h20, 32'h0000A5C3);
      @(negedge CLK);
      check("sh1_b1_gnt", {30'h0, GNT1, GNT0}, 32'h0);
      check("sh1_b1_we", {31'h0, MEM_WE}, 32'h1);
      check("sh1_b1_f3", {30'h0, MEM_FUNCT3}, 32'h0);
      check("sh1_b1_addr", MEM_ADDR, 32'h20);
      check("sh1_b1_byte", MEM_WDATA & 32'hFF, 32'hA5);
      @(negedge CLK);
      check("sh1_b2_gnt", {30'h0, GNT1, GNT0}, 32'h2);
      check("sh1_b2_we", {31'h0, MEM_WE}, 32'h1);
      check("sh1_b2_f3", {30'h0, MEM_FUNCT3}, 32'h0);
      check("sh1_b2_addr", MEM_ADDR, 32'h21);
      check("sh1_b2_byte", MEM_WDATA & 32'hFF, 32'hC3);
      @(posedge CLK);
      #1;
      release_port(1);
      check("sh1_mem20", {24'h0, mem[8'h20]}, 32'hA5);
      check("sh1_mem21", {24'h0, mem[8'h21]}, 32'hC3);
      do_load(1, 3'd1, 32'h20, 32'hFFFFA5C3, "lh1");
      do_load(1, 3'd5, 32'h20, 32'h0000A5C3, "lhu1");

      // sb, sign/zero byte loads, unsupported funct3
      access(0, 1'b1, 3'd0, 32'h50, 32'h12345680, 0, "sb0");
      check("sb0_we", {31'h0, g_we}, 32'h1);
      check("sb0_f3", {30'h0, g_f3}, 32'h0);
      check("sb0_byte", g_wdata & 32'hFF, 32'h80);
      do_load(0, 3'd0, 32'h50, 32'hFFFFFF80, "lb0");
      do_load(0, 3'd4, 32'h50, 32'h00000080, "lbu0b");
      do_load(1, 3'd3, 32'h10, 32'h0, "badld1");
      check("badld1_we", {31'h0, g_we}, 32'h0);
      check("rdata0_hold", RDATA0, 32'h80);
      access(0, 1'b1, 3'd3, 32'h60, 32'hFFFFFFFF, 0, "badst0");
      check("badst0_we", {31'h0, g_we}, 32'h0);
      check("badst0_mem", {24'h0, mem[8'h60]}, 32'h3A);

      // both requesting from reset: bursts of MAX_HOLD, no idle cycle
      RST = 1;
      idle_all();
      drive(0, 1'b1, 3'd2, 32'h40, 32'h11111111);
      drive(1, 1'b1, 3'd2, 32'h44, 32'h22222222);
      @(negedge CLK);
      check("rr_rst_gnt", {30'h0, GNT1, GNT0}, 32'h0);
      @(posedge CLK);
      #1;
      RST = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         check($sformatf("rr_%0d", i), {30'h0, GNT1, GNT0},
               (((i / 4) % 2) == 0) ? 32'h1 : 32'h2);
      end
      @(posedge CLK);
      #1;
      idle_all();

      // sh on port 0 is not preempted by port 1
      do_reset();
      q1.push_back(32'hDEADBEEF);
      drive(0, 1'b1, 3'd1, 32'h30, 32'h00001234);
      drive(1, 1'b0, 3'd2, 32'h10, 32'h0);
      @(negedge CLK);
      check("shp_b1_gnt", {30'h0, GNT1, GNT0}, 32'h0);
      check("shp_b1_addr", MEM_ADDR, 32'h30);
      check("shp_b1_byte", MEM_WDATA & 32'hFF, 32'h12);
      @(negedge CLK);
      check("shp_b2_gnt", {30'h0, GNT1, GNT0}, 32'h1);
      check("shp_b2_addr", MEM_ADDR, 32'h31);
      check("shp_b2_byte", MEM_WDATA & 32'hFF, 32'h34);
      @(posedge CLK);
      #1;
      release_port(0);
      @(negedge CLK);
      check("shp_gnt1", {30'h0, GNT1, GNT0}, 32'h2);
      @(posedge CLK);
      #1;
      release_port(1);
      check("shp_rv1", {31'h0, RVALID1}, 32'h1);

      // reset during the second beat aborts it
      do_reset();
      drive(0, 1'b1, 3'd1, 32'h38, 32'h00005566);
      drive(1, 1'b1, 3'd2, 32'h44, 32'h0BADF00D);
      @(negedge CLK);
      check("shr_b1_we", {31'h0, MEM_WE}, 32'h1);
      check("shr_b1_addr", MEM_ADDR, 32'h38);
      @(posedge CLK);
      #1;
      RST = 1;
      @(negedge CLK);
      check("shr_rst_gnt", {30'h0, GNT1, GNT0}, 32'h0);
      check("shr_rst_we", {31'h0, MEM_WE}, 32'h0);
      check("shr_rst_addr", MEM_ADDR, 32'h0);
      check("shr_rst_wdata", MEM_WDATA, 32'h0);
      check("shr_rst_f3", {30'h0, MEM_FUNCT3}, 32'h2);
      @(posedge CLK);
      #1;
      RST = 0;
      idle_all();
      @(negedge CLK);
      check("shr_idle_gnt", {30'h0, GNT1, GNT0}, 32'h0);
      check("shr_idle_rv", {30'h0, RVALID1, RVALID0}, 32'h0);
      check("shr_idle_rdata0", RDATA0, 32'h0);
      check("shr_idle_rdata1", RDATA1, 32'h0);
      check("shr_mem38", {24'h0, mem[8'h38]}, 32'h55);
      check("shr_mem39", {24'h0, mem[8'h39]}, 32'h63);
      @(posedge CLK);
      #1;
      drive(1, 1'b1, 3'd2, 32'h44, 32'h0BADF00D);
      access(0, 1'b1, 3'd2, 32'h48, 32'hCAFEF00D, 0, "post_rst0");
      check("post_rst0_addr", g_addr, 32'h48);
      check("post_rst0_other", {31'h0, g_other}, 32'h0);
      access(1, 1'b1, 3'd2, 32'h44, 32'h0BADF00D, 0, "post_rst1");
      check("post_rst1_addr", g_addr, 32'h44);

`ifdef DMEM_MISALIGN_CHECK_EN
      access(0, 1'b1, 3'd2, 32'h13, 32'hCAFEBABE, 0, "mis_sw0");
      check("mis_sw0_err", {31'h0, g_err}, 32'h1);
      check("mis_sw0_we", {31'h0, g_we}, 32'h0);
      check("mis_sw0_mem13", {24'h0, mem[8'h13]}, 32'h49);
      check("mis_sw0_mem14", {24'h0, mem[8'h14]}, 32'h4E);
      do_load(0, 3'd2, 32'h11, 32'h0, "mis_lw0");
      check("mis_lw0_err", {31'h0, g_err}, 32'h1);
`endif

      repeat (3) @(posedge CLK);
      #1;
      check("q0_left", q0.size(), 32'h0);
      check("q1_left", q1.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
